wptr_full_ctrl: RTL and testbench

Write-side pointer and status controller for the asynchronous FIFO, running entirely in the write clock domain. It accepts write requests and produces the binary write address for the dual-port memory. It also produces the registered gray write pointer that is handed to the write-to-read synchronizer. It consumes the read pointer after it has been synchronized into the write domain, and from it derives full, almost-full and fill level.

---
 rtl/wptr_full_ctrl.sv | 90 +++++++++
 tb/tb_wptr_full_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full/almost-full flags and fill level for an async FIFO.
// Optional sticky overflow status: define WPTR_OVERFLOW_STATUS_EN.
module wptr_full_ctrl #(
  parameter int PTR_WIDTH      = 4,
  parameter int ALMOST_FULL_TH = 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [PTR_WIDTH:0]   rptr_gray_sync,
`ifdef WPTR_OVERFLOW_STATUS_EN
  input  logic                 wovf_clr,
  output logic                 wovf,
`endif
  output logic                 wen,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH:0]   wptr_gray,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [PTR_WIDTH:0]   wlevel
);

  localparam int AW = PTR_WIDTH + 1;
  localparam logic [AW-1:0] DEPTH  = AW'(1 << PTR_WIDTH);
  localparam logic [AW-1:0] AF_LVL = DEPTH - AW'(ALMOST_FULL_TH);

  logic [AW-1:0] wbin;
  logic [AW-1:0] wbin_next;
  logic [AW-1:0] wgray_next;
  logic [AW-1:0] rbin_s;
  logic [AW-1:0] wlevel_next;
  logic [AW-1:0] rfull_cmp;
  logic          wfull_next;
  logic          walmost_full_next;

  // Gate with reset so no write strobe escapes while held in reset.
  assign wen   = winc & ~wfull & wrst_n;
  assign waddr = wbin[PTR_WIDTH-1:0];

  // Gray-to-binary of the synchronized read pointer (MSB-down XOR prefix).
  always_comb begin
    rbin_s = '0;
    rbin_s[AW-1] = rptr_gray_sync[AW-1];
    for (int i = AW - 2; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ rptr_gray_sync[i];
    end
  end

  // Next pointer, level and flag values for this cycle.
  always_comb begin
    wbin_next   = wbin + {{PTR_WIDTH{1'b0}}, wen};
    wgray_next  = wbin_next ^ (wbin_next >> 1);
    wlevel_next = wbin_next - rbin_s;
    rfull_cmp   = {~rptr_gray_sync[AW-1:AW-2],
                   rptr_gray_sync[AW-3:0]};
    wfull_next  = (wgray_next == rfull_cmp);
    walmost_full_next = (wlevel_next >= AF_LVL);
  end

  // Pointer and status registers; gray pointer is a pure flop output.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wlevel       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wlevel       <= wlevel_next;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
    end
  end

`ifdef WPTR_OVERFLOW_STATUS_EN
  // Sticky overflow: a dropped write sets it, clear loses to set.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl: directed scenarios plus random
// traffic against a write/read count model.
module tb_wptr_full_ctrl;

  localparam int PW    = 4;
  localparam int TH    = 2;
  localparam int DEPTH = 16;

  logic          wclk;
  logic          wrst_n;
  logic          winc;
  logic [PW:0]   rptr_gray_sync;
  logic          wovf_clr;
  logic          wovf;
  logic          wen;
  logic [PW-1:0] waddr;
  logic [PW:0]   wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [PW:0]   wlevel;

  wptr_full_ctrl #(.PTR_WIDTH(PW), .ALMOST_FULL_TH(TH)) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .winc(winc),
    .rptr_gray_sync(rptr_gray_sync),
`ifdef WPTR_OVERFLOW_STATUS_EN
    .wovf_clr(wovf_clr),
    .wovf(wovf),
`endif
    .wen(wen),
    .waddr(waddr),
    .wptr_gray(wptr_gray),
    .wfull(wfull),
    .walmost_full(walmost_full),
    .wlevel(wlevel)
  );

`ifndef WPTR_OVERFLOW_STATUS_EN
  assign wovf = 1'b0;
`endif

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    bit       wen;
    int       pre_addr;
    int       gray;
    int       addr;
    bit       full;
    bit       af;
    int       lvl;
    bit       ovf;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Model state: total words written / read since reset.
  int  m_w;
  int  m_r;
  bit  m_full;
  bit  m_ovf;

  function automatic logic [PW:0] gray5(input int n);
    logic [PW:0] b;
    b = PW'(0);
    b = n[PW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push what the DUT must show.
  task automatic drive(input bit inc, input int rc, input bit clr);
    exp_t e;
    int   lvl;
    bit   acc;
    @(negedge wclk);
    winc           = inc;
    rptr_gray_sync = gray5(rc);
    wovf_clr       = clr;
    acc        = inc && !m_full;
    e.wen      = acc;
    e.pre_addr = m_w % DEPTH;
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    m_w    = m_w + int'(acc);
    m_r    = rc;
    lvl    = m_w - m_r;
    m_full = (lvl == DEPTH);
    e.gray = int'(gray5(m_w % 32));
    e.addr = m_w % DEPTH;
    e.full = m_full;
    e.af   = (lvl >= DEPTH - TH);
    e.lvl  = lvl;
    e.ovf  = m_ovf;
    q.push_back(e);
  endtask

  // Monitor: check wen/waddr before the edge, registered state after.
  initial begin
    forever begin
      @(negedge wclk);
      #2;
      if (q.size() > 0) begin
        chk("wen", 32'(wen), 32'(q[0].wen));
        chk("waddr_pre", 32'(waddr), 32'(q[0].pre_addr));
        @(posedge wclk);
        #1;
        chk("wptr_gray", 32'(wptr_gray), 32'(q[0].gray));
        chk("waddr", 32'(waddr), 32'(q[0].addr));
        chk("wfull", 32'(wfull), 32'(q[0].full));
        chk("walmost_full", 32'(walmost_full), 32'(q[0].af));
        chk("wlevel", 32'(wlevel), 32'(q[0].lvl));
`ifdef WPTR_OVERFLOW_STATUS_EN
        chk("wovf", 32'(wovf), 32'(q[0].ovf));
`endif
        void'(q.pop_front());
      end
    end
  end

  task automatic drain_q();
    int n;
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge wclk);
      n++;
    end
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gray"}, 32'(wptr_gray), 32'd0);
    chk({tag, "_waddr"}, 32'(waddr), 32'd0);
    chk({tag, "_full"}, 32'(wfull), 32'd0);
    chk({tag, "_af"}, 32'(walmost_full), 32'd0);
    chk({tag, "_lvl"}, 32'(wlevel), 32'd0);
    chk({tag, "_wen"}, 32'(wen), 32'd0);
`ifdef WPTR_OVERFLOW_STATUS_EN
    chk({tag, "_ovf"}, 32'(wovf), 32'd0);
`endif
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_full = 0; m_ovf = 0;
  endtask

  task automatic random_phase(input int n);
    int rc;
    bit inc;
    rc = m_r;
    for (int i = 0; i < n; i++) begin
      inc = ($urandom_range(0, 3) != 0);
      if (rc < m_w && $urandom_range(0, 2) == 0)
        rc = rc + 1;
      drive(inc, rc, ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    model_reset();
    winc = 0; rptr_gray_sync = '0; wovf_clr = 0;
    wrst_n = 0;
    #12;
    winc = 1;
    #1;
    chk_reset_state("por");
    winc = 0;
    @(negedge wclk);
    wrst_n = 1;

    // Fill from empty with read pointer at 0, one extra request.
    for (int i = 0; i < 17; i++) drive(1, 0, 0);
    // Release from full, then drop below almost-full.
    drive(0, 1, 0);
    drive(0, 4, 0);
    // Move to level 8, then write and read together.
    drive(0, 8, 0);
    drive(1, 9, 0);
    drive(0, 9, 0);
    // Wrap with read pointer trailing by one word.
    for (int i = 0; i < 40; i++) drive(1, m_w, 0);
    // Refill to full, overflow, hold, clear, clear vs set.
    for (int i = 0; i < 18; i++) drive(1, m_r, 0);
    drive(0, m_r, 0);
    drive(0, m_r, 1);
    drive(0, m_r, 0);
    drive(1, m_r, 1);
    drive(0, m_r, 0);

    random_phase(300);
    drain_q();

    // Asynchronous reset in the middle of a cycle.
    @(negedge wclk);
    #3;
    winc = 1;
    wrst_n = 0;
    #1;
    chk_reset_state("async");
    model_reset();
    winc = 0;
    rptr_gray_sync = '0;
    @(negedge wclk);
    wrst_n = 1;

    random_phase(300);
    drain_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
